// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-side transmit path: transmitter state
// encoding, common keyboard command bytes, the device ACK code and the
// parity helper used when a command byte is captured.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RTS   = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_ACK   = 3'd4,
    ST_DONE  = 3'd5
  } tx_state_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ECHO    = 8'hEE;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] ACK_CODE    = 8'hFA;

  // Edge counter value held while waiting for the stop-bit edge (edge 10).
  localparam logic [3:0] EDGE_BEFORE_STOP = 4'd9;

  // Odd parity bit: makes the total number of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock conditioning: two-flop synchroniser followed by a saturating
// glitch filter. A new line level is accepted only after FILTER_LEN
// consecutive samples disagree with the current one; fall_tick pulses for
// one cycle on every accepted 1->0 transition. Shared with the receive path.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2c_in,
  output logic fall_tick
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          level_next_s;
  logic          fall_tick_r;
  logic          fall_next_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;

  // Bring the asynchronous clock line into the clk domain (idle level is high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= ps2c_in;
      sync2_r <= sync1_r;
    end
  end

  // Count consecutive samples that differ from the accepted level; flip on saturation.
  always_comb begin
    cnt_next_s   = '0;
    level_next_s = level_r;
    fall_next_s  = 1'b0;
    if (sync2_r != level_r) begin
      if (cnt_r == CNT_LAST) begin
        level_next_s = sync2_r;
        fall_next_s  = level_r;
        cnt_next_s   = '0;
      end else begin
        cnt_next_s = cnt_r + 1'b1;
      end
    end else begin
      cnt_next_s = '0;
    end
  end

  // Filter state and registered falling-edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r     <= 1'b1;
      cnt_r       <= '0;
      fall_tick_r <= 1'b0;
    end else begin
      level_r     <= level_next_s;
      cnt_r       <= cnt_next_s;
      fall_tick_r <= fall_next_s;
    end
  end

  assign fall_tick = fall_tick_r;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Sends one command byte with the full
// sequence: clock inhibit, start bit, 8 data bits LSB first, odd parity,
// stop bit and device ACK sample. The open-drain lines are driven through
// registered active-high pull-low enables; the tri-states live above.
// Optional feature macro: PS2_TX_TIMEOUT_EN adds a per-transfer watchdog
// (TIMEOUT_CYCLES) that releases the lines and flags ack_err.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk_Nexys,
  input  logic       Reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       ack_err
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);

  // The inhibit must outlast the clock filter, and the watchdog needs a sane limit.
  if ((INHIBIT_CYCLES < FILTER_LEN + 3) || (TIMEOUT_CYCLES < 2)) begin : g_bad_params
    $error("ps2_host_tx: INHIBIT_CYCLES or TIMEOUT_CYCLES out of range");
  end

  tx_state_e     state_r;
  tx_state_e     state_next_s;
  logic [IW-1:0] inh_cnt_r;
  logic [IW-1:0] inh_cnt_next_s;
  logic [3:0]    edge_cnt_r;
  logic [3:0]    edge_cnt_next_s;
  logic [8:0]    bits_r;
  logic [8:0]    bits_next_s;
  logic          ps2c_oe_r;
  logic          ps2c_oe_next_s;
  logic          ps2d_oe_r;
  logic          ps2d_oe_next_s;
  logic          ack_err_r;
  logic          ack_err_next_s;
  logic          done_tick_r;
  logic          tx_idle_r;
  logic          ps2d_meta_r;
  logic          ps2d_sync_r;
  logic          fall_tick_s;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt_r;
  logic [TW-1:0] to_cnt_next_s;
`endif

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk       (clk_Nexys),
    .rst_n     (Reset),
    .ps2c_in   (ps2c_in),
    .fall_tick (fall_tick_s)
  );

  // Two-flop synchroniser for the data line, used only for the ACK sample.
  always_ff @(posedge clk_Nexys or negedge Reset) begin
    if (!Reset) begin
      ps2d_meta_r <= 1'b1;
      ps2d_sync_r <= 1'b1;
    end else begin
      ps2d_meta_r <= ps2d_in;
      ps2d_sync_r <= ps2d_meta_r;
    end
  end

  // Next-state and next-output logic for the transmit sequence.
  always_comb begin
    state_next_s    = state_r;
    inh_cnt_next_s  = inh_cnt_r;
    edge_cnt_next_s = edge_cnt_r;
    bits_next_s     = bits_r;
    ps2c_oe_next_s  = ps2c_oe_r;
    ps2d_oe_next_s  = ps2d_oe_r;
    ack_err_next_s  = ack_err_r;
    case (state_r)
      ST_IDLE: begin
        ps2c_oe_next_s = 1'b0;
        ps2d_oe_next_s = 1'b0;
        if (wr_ps2) begin
          bits_next_s    = {odd_parity(din), din};
          ack_err_next_s = 1'b0;
          inh_cnt_next_s = '0;
          ps2c_oe_next_s = 1'b1;
          state_next_s   = ST_RTS;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RTS: begin
        if (inh_cnt_r == INH_LAST) begin
          // Release the clock and present the start bit (0) together.
          ps2c_oe_next_s = 1'b0;
          ps2d_oe_next_s = 1'b1;
          state_next_s   = ST_START;
        end else begin
          inh_cnt_next_s = inh_cnt_r + 1'b1;
        end
      end
      ST_START: begin
        if (fall_tick_s) begin
          // Edge 1: present din[0]; the shift register feeds later bits.
          ps2d_oe_next_s  = ~bits_r[0];
          bits_next_s     = {1'b0, bits_r[8:1]};
          edge_cnt_next_s = 4'd1;
          state_next_s    = ST_DATA;
        end else begin
          state_next_s = ST_START;
        end
      end
      ST_DATA: begin
        if (fall_tick_s) begin
          if (edge_cnt_r == EDGE_BEFORE_STOP) begin
            // Edge 10: stop bit is a released (high) line.
            ps2d_oe_next_s = 1'b0;
            state_next_s   = ST_ACK;
          end else begin
            // Edges 2..9: remaining data bits, then parity.
            ps2d_oe_next_s  = ~bits_r[0];
            bits_next_s     = {1'b0, bits_r[8:1]};
            edge_cnt_next_s = edge_cnt_r + 4'd1;
          end
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_ACK: begin
        if (fall_tick_s) begin
          // Edge 11: a device ACK holds data low; high means NACK.
          ack_err_next_s = ps2d_sync_r;
          state_next_s   = ST_DONE;
        end else begin
          state_next_s = ST_ACK;
        end
      end
      ST_DONE: begin
        ps2c_oe_next_s = 1'b0;
        ps2d_oe_next_s = 1'b0;
        state_next_s   = ST_IDLE;
      end
      default: begin
        ps2c_oe_next_s = 1'b0;
        ps2d_oe_next_s = 1'b0;
        state_next_s   = ST_IDLE;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    to_cnt_next_s = '0;
    if ((state_r == ST_START) || (state_r == ST_DATA) || (state_r == ST_ACK)) begin
      if (to_cnt_r == TO_LAST) begin
        // Device stopped clocking: give the bus back and report failure.
        ps2c_oe_next_s = 1'b0;
        ps2d_oe_next_s = 1'b0;
        ack_err_next_s = 1'b1;
        state_next_s   = ST_DONE;
        to_cnt_next_s  = '0;
      end else begin
        to_cnt_next_s = to_cnt_r + 1'b1;
      end
    end else begin
      to_cnt_next_s = '0;
    end
`endif
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk_Nexys or negedge Reset) begin
    if (!Reset) begin
      state_r     <= ST_IDLE;
      inh_cnt_r   <= '0;
      edge_cnt_r  <= 4'd0;
      bits_r      <= 9'd0;
      ps2c_oe_r   <= 1'b0;
      ps2d_oe_r   <= 1'b0;
      ack_err_r   <= 1'b0;
      done_tick_r <= 1'b0;
      tx_idle_r   <= 1'b1;
    end else begin
      state_r     <= state_next_s;
      inh_cnt_r   <= inh_cnt_next_s;
      edge_cnt_r  <= edge_cnt_next_s;
      bits_r      <= bits_next_s;
      ps2c_oe_r   <= ps2c_oe_next_s;
      ps2d_oe_r   <= ps2d_oe_next_s;
      ack_err_r   <= ack_err_next_s;
      done_tick_r <= (state_next_s == ST_DONE);
      tx_idle_r   <= (state_next_s == ST_IDLE);
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  // Watchdog counter, running from START entry until the transfer ends.
  always_ff @(posedge clk_Nexys or negedge Reset) begin
    if (!Reset) begin
      to_cnt_r <= '0;
    end else begin
      to_cnt_r <= to_cnt_next_s;
    end
  end
`endif

  assign ps2c_oe      = ps2c_oe_r;
  assign ps2d_oe      = ps2d_oe_r;
  assign tx_idle      = tx_idle_r;
  assign tx_done_tick = done_tick_r;
  assign ack_err      = ack_err_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a device model clocks the bus with wired-AND lines,
// records the frame on rising clock edges and compares against a parity model.
module tb_ps2_host_tx;

  localparam int INHIBIT = 200;
  localparam int FLEN    = 8;
  localparam int TMO     = 3000;
  localparam int HALF    = 40;

  typedef struct {
    logic [7:0] din;
    bit         ack;
    bit         exp_par;
    bit         exp_err;
    int         wr_edge;
    int         glitch_edge;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_ps2;
  logic [7:0] din;
  logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, ack_err;
  logic       dev_c, dev_d, glitch;
  logic       ps2c_line, ps2d_line;

  int checks = 0;
  int failures = 0;
  int done_total = 0;
  vec_t tbl[8];

  assign ps2c_line = dev_c & ~ps2c_oe & ~glitch;
  assign ps2d_line = dev_d & ~ps2d_oe;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done_tick === 1'b1) done_total <= done_total + 1;
  end

  ps2_host_tx #(
    .INHIBIT_CYCLES (INHIBIT),
    .FILTER_LEN     (FLEN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_Nexys    (clk),
    .Reset        (rst_n),
    .wr_ps2       (wr_ps2),
    .din          (din),
    .ps2c_in      (ps2c_line),
    .ps2d_in      (ps2d_line),
    .ps2c_oe      (ps2c_oe),
    .ps2d_oe      (ps2d_oe),
    .tx_idle      (tx_idle),
    .tx_done_tick (tx_done_tick),
    .ack_err      (ack_err)
  );

  // Reference rule: parity bit makes the count of ones in data+parity odd.
  function automatic bit model_parity(input logic [7:0] b);
    return (($countones(b) % 2) == 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_transfer(input vec_t v, input int abort_edge);
    logic [10:0] frame;
    int inh;
    int base;
    int wait_n;
    frame = '0;
    base = done_total;
    @(negedge clk); din = v.din; wr_ps2 = 1'b1;
    @(negedge clk); wr_ps2 = 1'b0;
    chk("accept_ack_err_clear", ack_err, 0);
    chk("accept_idle_low", tx_idle, 0);
    inh = 0;
    while (ps2c_oe === 1'b1 && inh < INHIBIT + 50) begin
      inh++;
      @(negedge clk);
    end
    chk("inhibit_len", inh, INHIBIT);
    chk("start_bit_driven", ps2d_oe, 1);
    chk("start_line_low", ps2d_line, 0);
    repeat (50) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) dev_d = v.ack ? 1'b0 : 1'b1;
      dev_c = 1'b0;
      if (k == abort_edge) begin
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_c_released", ps2c_oe, 0);
        chk("abort_d_released", ps2d_oe, 0);
        @(negedge clk);
        rst_n = 1'b1; dev_c = 1'b1; dev_d = 1'b1;
        @(negedge clk);
        chk("abort_idle_after_release", tx_idle, 1);
        repeat (20) @(negedge clk);
        return;
      end
      if (k == v.wr_edge) begin
        repeat (20) @(negedge clk);
        din = 8'h55; wr_ps2 = 1'b1;
        @(negedge clk); wr_ps2 = 1'b0;
        repeat (HALF - 21) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      dev_c = 1'b1;
      frame[k-1] = ps2d_line;
      if (k == v.glitch_edge) begin
        repeat (10) @(negedge clk);
        glitch = 1'b1;
        repeat (3) @(negedge clk);
        glitch = 1'b0;
        repeat (HALF - 13) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      if (k == 11) dev_d = 1'b1;
    end
    wait_n = 0;
    while (tx_idle !== 1'b1 && wait_n < 200) begin
      wait_n++;
      @(negedge clk);
    end
    chk("idle_return", tx_idle, 1);
    repeat (2) @(negedge clk);
    chk("data_byte", frame[7:0], v.din);
    chk("parity_bit", frame[8], v.exp_par);
    chk("stop_bit", frame[9], 1);
    chk("done_tick_count", done_total - base, 1);
    chk("ack_err", ack_err, v.exp_err);
    chk("lines_released", {ps2c_oe, ps2d_oe}, 0);
    repeat (20) @(negedge clk);
    chk("no_queued_transfer", {tx_idle, ps2c_oe}, 2);
    chk("ack_err_held", ack_err, v.exp_err);
  endtask

  initial begin
    int n;
    int base;
    vec_t v;
    rst_n = 1'b0; wr_ps2 = 1'b0; din = 8'h00;
    dev_c = 1'b1; dev_d = 1'b1; glitch = 1'b0;

    tbl[0] = '{din: 8'hED, ack: 1'b1, exp_par: 1'b1, exp_err: 1'b0, wr_edge: 0, glitch_edge: 0};
    tbl[1] = '{din: 8'h01, ack: 1'b0, exp_par: 1'b0, exp_err: 1'b1, wr_edge: 0, glitch_edge: 0};
    tbl[2] = '{din: 8'hA3, ack: 1'b1, exp_par: 1'b1, exp_err: 1'b0, wr_edge: 3, glitch_edge: 0};
    tbl[3] = '{din: 8'hC6, ack: 1'b1, exp_par: 1'b1, exp_err: 1'b0, wr_edge: 0, glitch_edge: 5};
    tbl[4] = '{din: 8'h00, ack: 1'b1, exp_par: 1'b1, exp_err: 1'b0, wr_edge: 0, glitch_edge: 0};
    for (int i = 5; i < 8; i++) begin
      tbl[i].din         = 8'($urandom);
      tbl[i].ack         = 1'($urandom);
      tbl[i].exp_par     = model_parity(tbl[i].din);
      tbl[i].exp_err     = !tbl[i].ack;
      tbl[i].wr_edge     = 0;
      tbl[i].glitch_edge = $urandom_range(1, 10);
    end

    repeat (3) @(negedge clk);
    chk("reset_ps2c_oe", ps2c_oe, 0);
    chk("reset_ps2d_oe", ps2d_oe, 0);
    chk("reset_done_tick", tx_done_tick, 0);
    chk("reset_ack_err", ack_err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_idle", tx_idle, 1);
    repeat (20) @(negedge clk);

    for (int i = 0; i < 8; i++) do_transfer(tbl[i], 0);

    // Reset during the clock inhibit releases the clock line at once.
    @(negedge clk); din = 8'hED; wr_ps2 = 1'b1;
    @(negedge clk); wr_ps2 = 1'b0;
    repeat (50) @(negedge clk);
    chk("rts_inhibit_active", ps2c_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("rts_reset_release_c", ps2c_oe, 0);
    chk("rts_reset_done_low", tx_done_tick, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rts_reset_idle", tx_idle, 1);
    repeat (20) @(negedge clk);

    // Reset after edge 4 of 0xFF, then a clean 0xFF transfer.
    v = '{din: 8'hFF, ack: 1'b1, exp_par: model_parity(8'hFF), exp_err: 1'b0, wr_edge: 0, glitch_edge: 0};
    do_transfer(v, 4);
    do_transfer(v, 0);

    // Silent device after the inhibit.
    base = done_total;
    @(negedge clk); din = 8'hEE; wr_ps2 = 1'b1;
    @(negedge clk); wr_ps2 = 1'b0;
    n = 0;
    while (ps2c_oe === 1'b1 && n < INHIBIT + 50) begin
      n++;
      @(negedge clk);
    end
    chk("silent_inhibit_len", n, INHIBIT);
`ifdef PS2_TX_TIMEOUT_EN
    n = 0;
    while (ps2d_oe === 1'b1 && n < TMO + 100) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_release_cycles", n, TMO);
    repeat (3) @(negedge clk);
    chk("timeout_done_tick", done_total - base, 1);
    chk("timeout_ack_err", ack_err, 1);
    chk("timeout_idle", tx_idle, 1);
`else
    repeat (TMO + 100) @(negedge clk);
    chk("no_timeout_busy", tx_idle, 0);
    chk("no_timeout_no_done", done_total - base, 0);
    chk("no_timeout_start_held", ps2d_oe, 1);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("no_timeout_recover_idle", tx_idle, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
